if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch producer that drives the IF/ID pipeline register.
//  Holds the fetch PC and issues in-order requests to instruction memory.
//  Tags each returned word with its PC and buffers it, then presents it to IF/ID.
//  Honours decode stall (hazard) and branch/jump redirect (flush) from later stages.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch PC after reset; bits [1:0] must be 0
//  DEPTH     2              buffer entries = max credits (in-flight + buffered); 2..8
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst_n          in   1   asynchronous active-low reset
//  stall_i        in   1   hazard: IF/ID holds, do not pop buffer head
//  redirect_i     in   1   flush: taken branch/jump resolved downstream
//  redirect_pc_i  in   32  new fetch target; bits [1:0] ignored (forced 0)
//  imem_req_o     out  1   fetch request valid
//  imem_addr_o    out  32  fetch address; bits [1:0] always 0
//  imem_gnt_i     in   1   request accepted this cycle (req && gnt = issue)
//  imem_rvalid_i  in   1   response valid; responses return in issue order
//  imem_rdata_i   in   32  response instruction word
//  valid_o        out  1   buffer head valid
//  pc_o           out  32  PC of head instruction; 0 when !valid_o
//  inst_o         out  32  head instruction; 32'b0 (pipeline bubble) when !valid_o
// BEHAVIOUR
//  Reset (async, rst_n=0): pc_q=RESET_PC, buffer empty, pending-PC queue empty,
//   outstanding=0, drop_cnt=0. Outputs: imem_req_o=0, valid_o=0, pc_o=0, inst_o=0.
//   imem_addr_o=RESET_PC. Reset mid-operation discards everything; imem shares rst_n.
//  Credits: imem_req_o = !redirect_i && (outstanding + count) < DEPTH. Buffer never overflows.
//   imem_addr_o = pc_q.
//  Issue (req && gnt): pc_q += 4 (wraps mod 2^32), outstanding++, push pc_q to pending-PC queue.
//   Without gnt, req and addr stay stable.
//  Response (rvalid), drop_cnt>0: drop_cnt--, outstanding--, pop pending PC, discard data.
//  Response (rvalid), drop_cnt==0: outstanding--, push {pending PC, rdata} into buffer.
//  Rvalid with outstanding==0 is a protocol error and is ignored (assertion in bench).
//  Output: valid_o/pc_o/inst_o are registered buffer-head state, no bypass.
//   Response in cycle N is visible at earliest in cycle N+1.
//   Pop when valid_o && !stall_i && !redirect_i. stall_i holds the head unchanged.
//   Push and pop in the same cycle are both legal; count stays the same.
//  Redirect (priority over stall, issue and push):
//   pc_q <= {redirect_pc_i[31:2],2'b00}.
//   Buffer cleared: valid_o=0 next cycle.
//   Pending-PC entries are kept, and drop_cnt <= outstanding_q - imem_rvalid_i.
//    Every in-flight fetch becomes stale.
//   The response arriving in the redirect cycle is consumed as a drop and never pushed.
//   No request in the redirect cycle. Next cycle fetches the target (credits permitting).
//   Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
//  Best-case latency: redirect at N; req+gnt at N+1; rvalid at N+2; valid_o at N+3.
//  Counters are $clog2(DEPTH)+1 bits wide.
//  Invariant: count + outstanding <= DEPTH.
//  Invariant: drop_cnt <= outstanding.
// TESTING
//  1. Reset release, gnt=1, rvalid 1 cycle after each gnt, no stall
//     -> addr 0,4,8,...; valid_o from cycle 2; pc_o/inst_o follow the rdata sequence.
//  2. stall_i held 5 cycles, DEPTH=2
//     -> head pc_o/inst_o constant; req drops once 2 credits are used; resumes 1 cycle after release.
//  3. Two fetches in flight (0x10, 0x14), redirect_i with redirect_pc_i=0x103
//     -> both responses dropped; next addr 0x100; first valid_o pc_o=0x100.
//  4. gnt=0 for 3 cycles with req high -> addr stable; pc_q does not advance; no valid_o.
//  5. Redirect in the same cycle as rvalid and stall
//     -> rvalid data never appears on inst_o; drop_cnt = outstanding-1; stall ignored.
//  6. pc_q=32'hFFFF_FFFC issue -> next addr 32'h0000_0000.
//     rst_n asserted mid-burst -> all outputs zero immediately (async).

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer: issues in-order imem requests under a credit limit,
// tags responses with their PC and buffers them for the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int UW = CW + 1;
    localparam int IW = $clog2(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] brd_q, brd_d, bwr_q, bwr_d;
    logic [IW-1:0] prd_q, prd_d, pwr_q, pwr_d;
    logic [31:0]   bpc_q   [DEPTH];
    logic [31:0]   bpc_d   [DEPTH];
    logic [31:0]   binst_q [DEPTH];
    logic [31:0]   binst_d [DEPTH];
    logic [31:0]   ppc_q   [DEPTH];
    logic [31:0]   ppc_d   [DEPTH];

    logic [UW-1:0] used;
    logic          can_req, issue, rsp, push, pop;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(DEPTH - 1)) ? '0 : i + 1'b1;
    endfunction

    // Credits cover both in-flight fetches and buffered words, so the buffer can never overflow.
    assign used    = {1'b0, out_q} + {1'b0, cnt_q};
    assign can_req = used < UW'(DEPTH);
    assign issue   = can_req && !redirect_i && imem_gnt_i;
    assign rsp     = imem_rvalid_i && (out_q != '0);
    assign push    = rsp && (drop_q == '0) && !redirect_i;
    assign pop     = valid_o && !stall_i && !redirect_i;

    assign imem_req_o  = rst_n && can_req && !redirect_i;
    assign imem_addr_o = pc_q;
    assign valid_o     = (cnt_q != '0);
    assign pc_o        = valid_o ? bpc_q[brd_q] : 32'h0;
    assign inst_o      = valid_o ? binst_q[brd_q] : 32'h0;

    always_comb begin
        pc_d    = pc_q;
        out_d   = out_q + CW'(issue) - CW'(rsp);
        drop_d  = drop_q;
        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        brd_d   = brd_q;
        bwr_d   = bwr_q;
        prd_d   = prd_q;
        pwr_d   = pwr_q;
        bpc_d   = bpc_q;
        binst_d = binst_q;
        ppc_d   = ppc_q;

        if (issue) begin
            ppc_d[pwr_q] = pc_q;
            pwr_d        = next_idx(pwr_q);
            pc_d         = pc_q + 32'd4;
        end
        if (rsp) begin
            prd_d = next_idx(prd_q);
            if (drop_q != '0) drop_d = drop_q - 1'b1;
        end
        if (push) begin
            bpc_d[bwr_q]   = ppc_q[prd_q];
            binst_d[bwr_q] = imem_rdata_i;
            bwr_d          = next_idx(bwr_q);
        end
        if (pop) brd_d = next_idx(brd_q);

        // Pending PCs stay queued; every fetch still in flight is marked stale instead.
        if (redirect_i) begin
            pc_d   = redirect_pc_i & 32'hFFFF_FFFC;
            cnt_d  = '0;
            brd_d  = '0;
            bwr_d  = '0;
            drop_d = out_q - CW'(rsp);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            out_q  <= '0;
            drop_q <= '0;
            cnt_q  <= '0;
            brd_q  <= '0;
            bwr_q  <= '0;
            prd_q  <= '0;
            pwr_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bpc_q[i]   <= 32'h0;
                binst_q[i] <= 32'h0;
                ppc_q[i]   <= 32'h0;
            end
        end else begin
            pc_q    <= pc_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            brd_q   <= brd_d;
            bwr_q   <= bwr_d;
            prd_q   <= prd_d;
            pwr_q   <= pwr_d;
            bpc_q   <= bpc_d;
            binst_q <= binst_d;
            ppc_q   <= ppc_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random traffic, checked each
// cycle against a queue-based model of the fetch/response/buffer rules.
module tb_if_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, redirect_i, imem_gnt_i, imem_rvalid_i;
    logic [31:0] redirect_pc_i, imem_rdata_i;
    logic        imem_req_o, valid_o;
    logic [31:0] imem_addr_o, pc_o, inst_o;

    if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .inst_o        (inst_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    ent_t        m_buf[$];
    int          m_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic        e_req;
        logic [31:0] e_pc, e_inst;
        e_req  = !redirect_i && ((m_pend.size() + m_buf.size()) < DEPTH);
        e_pc   = (m_buf.size() > 0) ? m_buf[0].pc : 32'h0;
        e_inst = (m_buf.size() > 0) ? m_buf[0].inst : 32'h0;
        check("req",   {31'b0, imem_req_o}, {31'b0, e_req});
        check("addr",  imem_addr_o, m_pc);
        check("valid", {31'b0, valid_o}, {31'b0, m_buf.size() > 0});
        check("pc",    pc_o, e_pc);
        check("inst",  inst_o, e_inst);
    endtask

    // One clock: drive inputs after the falling edge, check, advance the model, take the rising edge.
    task automatic step(input logic g, input logic rv, input logic st, input logic rd,
                        input logic [31:0] rpc);
        logic        do_req, issue, rsp, do_pop;
        int          old_out;
        logic [31:0] p;
        ent_t        e;
        @(negedge clk);
        imem_gnt_i    = g;
        imem_rvalid_i = rv && (m_pend.size() > 0);
        imem_rdata_i  = $urandom;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        #1;
        check_outputs();
        do_req  = !rd && ((m_pend.size() + m_buf.size()) < DEPTH);
        issue   = do_req && g;
        rsp     = imem_rvalid_i;
        old_out = m_pend.size();
        do_pop  = (m_buf.size() > 0) && !st && !rd;
        if (do_pop) void'(m_buf.pop_front());
        if (rsp) begin
            p = m_pend.pop_front();
            if (m_drop > 0) m_drop--;
            else if (!rd) begin
                e.pc   = p;
                e.inst = imem_rdata_i;
                m_buf.push_back(e);
            end
        end
        if (rd) begin
            m_buf.delete();
            m_drop = old_out - (rsp ? 1 : 0);
            m_pc   = {rpc[31:2], 2'b00};
        end else if (issue) begin
            m_pend.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst_n         = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        #1;
        check("rst_req",   {31'b0, imem_req_o}, 32'h0);
        check("rst_addr",  imem_addr_o, RESET_PC);
        check("rst_valid", {31'b0, valid_o}, 32'h0);
        check("rst_pc",    pc_o, 32'h0);
        check("rst_inst",  inst_o, 32'h0);
        m_pc   = RESET_PC;
        m_drop = 0;
        m_pend.delete();
        m_buf.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic expect_first_valid(input string tag, input logic [31:0] exp_pc);
        int n = 0;
        #1;
        while (!valid_o && n < 12) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            #1;
            n++;
        end
        check({tag, "_valid"}, {31'b0, valid_o}, 32'h1);
        check({tag, "_pc"}, pc_o, exp_pc);
    endtask

    task automatic drain();
        repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        do_reset();

        repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

        repeat (5) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

        drain();
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0010);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0103);
        expect_first_valid("t3", 32'h0000_0100);

        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drain();

        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0080);
        #1;
        check("t5_flush", {31'b0, valid_o}, 32'h0);
        expect_first_valid("t5a", 32'h0000_0080);
        drain();
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0300);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_first_valid("t5b", 32'h0000_0300);

        drain();
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check("t6_wrap", imem_addr_o, 32'h0000_0000);
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) do_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
